// File: rtl/fb_scanout_pkg.sv
// fb_scanout shared definitions: VGA 640x480@60 timing,
// framebuffer geometry and scanout pipeline bundles.
package fb_scanout_pkg;

  localparam int FB_AW = 19;
  localparam int FB_W  = 640;
  localparam int FB_H  = 480;
  localparam int CW    = 10;

  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;
  localparam int H_TOTAL_DEF = FB_W + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = FB_H + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SS_DEF    = FB_W + H_FP_DEF;
  localparam int H_SE_DEF    = H_SS_DEF + H_SYNC_DEF - 1;
  localparam int V_SS_DEF    = FB_H + V_FP_DEF;
  localparam int V_SE_DEF    = V_SS_DEF + V_SYNC_DEF - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic ce;
    logic hs;
    logic vs;
    logic de;
    logic vb;
  } scan_s1_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic col;
    logic vb;
  } scan_out_t;

  function automatic logic in_win(
    input logic [CW-1:0] x,
    input int            lo,
    input int            hi
  );
    return (int'(x) >= lo) && (int'(x) <= hi);
  endfunction

endpackage

// File: rtl/fb_scan_timing.sv
// VGA raster counters with IDLE/RUN control and
// combinational sync / data-enable / vblank decode.
module fb_scan_timing
  import fb_scanout_pkg::*;
#(
  parameter int H_ACTIVE = FB_W,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = FB_H,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          pix_ce,
  output logic          live,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          hs_n,
  output logic          vs_n,
  output logic          de,
  output logic          vb
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC - 1;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC - 1;

  scan_state_e   state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          step, h_wrap, v_wrap;

  // IDLE with enable high is already the (0,0) slot
  always_comb begin
    live   = (state_q == RUN) || (enable && reset);
    step   = live && pix_ce;
    h_wrap = (h_q == CW'(HT - 1));
    v_wrap = (v_q == CW'(VT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (step) state_d = RUN;
      RUN:
        if (step && h_wrap && v_wrap && !enable)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (step) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    h    = h_q;
    v    = v_q;
    hs_n = !(live && in_win(h_q, HS0, HS1));
    vs_n = !(live && in_win(v_q, VS0, VS1));
    de   = live && (int'(h_q) < H_ACTIVE)
                && (int'(v_q) < V_ACTIVE);
    vb   = live && (int'(v_q) >= V_ACTIVE);
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: timing, row-major read address
// counter and two-stage output pipeline to the DAC.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int H_ACTIVE = FB_W,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = FB_H,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pix_ce,
  output logic             FB_RE,
  output logic [FB_AW-1:0] FB_addr,
  input  logic             FB_data,
  output logic             hsync,
  output logic             vsync,
  output logic             video_de,
  output logic             color_out,
  output logic             vblank,
  output logic             frame_start
);

  localparam logic [FB_AW-1:0] ADDR_LAST =
    FB_AW'(H_ACTIVE * V_ACTIVE - 1);
  localparam scan_s1_t  S1_RST  = '{ce: 1'b0, hs: 1'b1,
    vs: 1'b1, de: 1'b0, vb: 1'b0};
  localparam scan_out_t OUT_RST = '{hs: 1'b1, vs: 1'b1,
    de: 1'b0, col: 1'b0, vb: 1'b0};

  logic             live, hs_n, vs_n, de, vb;
  logic [CW-1:0]    h, v;
  logic [FB_AW-1:0] addr_q, addr_d;
  scan_s1_t         s1_q, s1_d;
  scan_out_t        out_q, out_d;

  fb_scan_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .pix_ce (pix_ce),
    .live   (live),
    .h      (h),
    .v      (v),
    .hs_n   (hs_n),
    .vs_n   (vs_n),
    .de     (de),
    .vb     (vb)
  );

  // reads are only issued in the active window, so the
  // wrap lands exactly on the next frame's first pixel
  always_comb begin
    FB_RE       = de && pix_ce;
    frame_start = live && pix_ce && (h == '0) && (v == '0);
    FB_addr     = addr_q;
    addr_d      = addr_q;
    if (FB_RE)
      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
  end

  always_comb begin
    s1_d  = '{ce: pix_ce, hs: hs_n, vs: vs_n, de: de, vb: vb};
    out_d = out_q;
    if (s1_q.ce)
      out_d = '{hs: s1_q.hs, vs: s1_q.vs, de: s1_q.de,
                col: s1_q.de & FB_data, vb: s1_q.vb};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      s1_q   <= S1_RST;
      out_q  <= OUT_RST;
    end else begin
      addr_q <= addr_d;
      s1_q   <= s1_d;
      out_q  <= out_d;
    end
  end

  always_comb begin
    hsync     = out_q.hs;
    vsync     = out_q.vs;
    video_de  = out_q.de;
    color_out = out_q.col;
    vblank    = out_q.vb;
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced 16x8 raster
// (8x4 active) so whole frames fit in a short run.
module tb_fb_scanout;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FRM = HT * VT;
  localparam int HS0 = HA + HFP;
  localparam int HS1 = HS0 + HSW - 1;
  localparam int VS0 = VA + VFP;
  localparam int VS1 = VS0 + VSW - 1;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pix_ce;
  logic        FB_RE;
  logic [18:0] FB_addr;
  logic        FB_data;
  logic        hsync;
  logic        vsync;
  logic        video_de;
  logic        color_out;
  logic        vblank;
  logic        frame_start;

  int checks;
  int failures;

  fb_scanout #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pix_ce      (pix_ce),
    .FB_RE       (FB_RE),
    .FB_addr     (FB_addr),
    .FB_data     (FB_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_de    (video_de),
    .color_out   (color_out),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // framebuffer contents: pixel value = address bit 0
  always @(posedge clk) FB_data <= FB_addr[0];

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    pix_ce = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (FB_RE !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_re cyc=%0d got=%b exp=0", i, FB_RE);
      end
    end
    checks++;
    if ({FB_addr, frame_start} !== 20'd0) begin
      failures++;
      $display("FAIL reset_addr_fs got=%h/%b exp=0/0",
               FB_addr, frame_start);
    end
    checks++;
    if ({hsync, vsync, video_de, color_out, vblank} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=11000",
               {hsync, vsync, video_de, color_out, vblank});
    end
  endtask

  // Cycle-by-cycle scan with a raster model; enable drops
  // for good once the model reaches line drop_v (if >= 0).
  task automatic test_scan(input string tag, input int ce_div,
                           input int ncyc, input int drop_v);
    int   h, v, ea, reads, last, nfs;
    bit   run, en, ce, live, re, fs, de, p1v, p2v;
    logic [4:0] cur, p1, p2, exp_out, got;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    pix_ce = 1'b0;
    @(negedge clk);
    h = 0; v = 0; run = 0; en = 1;
    p1v = 0; p2v = 0; p1 = '0; p2 = '0;
    exp_out = 5'b11000;
    reads = 0; last = -1; nfs = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      reset = 1'b1;
      ce = (k % ce_div) == 0;
      if (drop_v >= 0 && v >= drop_v) en = 0;
      enable = en;
      pix_ce = ce;
      #1;
      if (p2v) exp_out = p2;
      live = run || en;
      re = live && ce && h < HA && v < VA;
      fs = live && ce && h == 0 && v == 0;
      de = live && h < HA && v < VA;
      ea = v * HA + h;
      checks++;
      if (FB_RE !== re) begin
        failures++;
        $display("FAIL %s re k=%0d got=%b exp=%b", tag, k, FB_RE, re);
      end
      checks++;
      if (frame_start !== fs) begin
        failures++;
        $display("FAIL %s fs k=%0d got=%b exp=%b",
                 tag, k, frame_start, fs);
      end
      if (re) begin
        checks++;
        if (FB_addr !== 19'(ea)) begin
          failures++;
          $display("FAIL %s addr k=%0d got=%0d exp=%0d",
                   tag, k, FB_addr, ea);
        end
      end
      got = {hsync, vsync, video_de, color_out, vblank};
      checks++;
      if (got !== exp_out) begin
        failures++;
        $display("FAIL %s outs k=%0d got=%b exp=%b",
                 tag, k, got, exp_out);
      end
      if (frame_start === 1'b1) begin
        if (nfs > 0) begin
          checks++;
          if (reads != HA * VA || last != HA * VA - 1) begin
            failures++;
            $display("FAIL %s frame_reads got=%0d/%0d exp=%0d/%0d",
                     tag, reads, last, HA * VA, HA * VA - 1);
          end
        end
        nfs++;
        reads = 0;
      end
      if (FB_RE === 1'b1) begin
        reads++;
        last = int'(FB_addr);
      end
      cur = {!(live && h >= HS0 && h <= HS1),
             !(live && v >= VS0 && v <= VS1),
             de, de && ea[0], live && v >= VA};
      p2 = p1; p2v = p1v;
      p1 = cur; p1v = ce;
      if (live && ce) begin
        run = 1;
        if (h == HT - 1) begin
          h = 0;
          if (v == VT - 1) begin
            v = 0;
            run = en;
          end else begin
            v++;
          end
        end else begin
          h++;
        end
      end
    end
  endtask

  task automatic test_full_rate();
    test_scan("full", 1, 2 * FRM + 8, -1);
  endtask

  task automatic test_half_rate();
    test_scan("half", 2, 2 * FRM + 20, -1);
  endtask

  task automatic test_enable_drop();
    test_scan("drop", 1, 2 * FRM + 40, 2);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    pix_ce = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({FB_RE, FB_addr, frame_start} !== 21'd0) begin
      failures++;
      $display("FAIL midrst_re_addr got=%b/%0d/%b exp=0/0/0",
               FB_RE, FB_addr, frame_start);
    end
    checks++;
    if ({hsync, vsync, video_de, color_out, vblank} !== 5'b11000) begin
      failures++;
      $display("FAIL midrst_outs got=%b exp=11000",
               {hsync, vsync, video_de, color_out, vblank});
    end
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    checks++;
    if ({FB_RE, frame_start, hsync} !== 3'b001) begin
      failures++;
      $display("FAIL midrst_idle got=%b exp=001",
               {FB_RE, frame_start, hsync});
    end
    @(negedge clk);
    enable = 1'b1;
    #1;
    checks++;
    if ({FB_RE, frame_start, FB_addr} !== {2'b11, 19'd0}) begin
      failures++;
      $display("FAIL midrst_restart got=%b/%b/%0d exp=1/1/0",
               FB_RE, frame_start, FB_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({FB_RE, frame_start, FB_addr} !== {2'b10, 19'd1}) begin
      failures++;
      $display("FAIL midrst_next got=%b/%b/%0d exp=1/0/1",
               FB_RE, frame_start, FB_addr);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    pix_ce   = 1'b0;
    test_reset();
    test_full_rate();
    test_half_rate();
    test_enable_drop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
